// File: rtl/matvec_ctrl.sv
// matvec_ctrl: sequencer for a K x K matrix / K-vector multiply datapath.
// Loads matrix and vector words from a valid/ready stream, then walks the
// matrix row by row issuing memory reads and MAC strobes, and presents each
// finished row on a valid/ready result handshake. Carries no data itself.
// Optional feature macro: MATVEC_CTRL_PERF_EN adds perf_jobs / perf_stall counters.
module matvec_ctrl #(
  parameter int unsigned K    = 8,
  parameter int unsigned MA_W = $clog2(K * K),
  parameter int unsigned VA_W = $clog2(K)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            input_valid,
  output logic            input_ready,
  input  logic            new_matrix,
  output logic            output_valid,
  input  logic            output_ready,
  output logic            wr_en_m,
  output logic [MA_W-1:0] wr_addr_m,
  output logic            wr_en_v,
  output logic [VA_W-1:0] wr_addr_v,
  output logic [MA_W-1:0] rd_addr_m,
  output logic [VA_W-1:0] rd_addr_v,
  output logic            mac_en,
  output logic            mac_clr
`ifdef MATVEC_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_jobs,
  output logic [31:0]     perf_stall
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StLoadM,
    StLoadV,
    StCompute,
    StDrain,
    StOut
  } state_e;

  localparam logic [MA_W-1:0] MLast = MA_W'(K * K - 1);
  localparam logic [VA_W-1:0] VLast = VA_W'(K - 1);

  state_e          state_q;
  logic [MA_W-1:0] mcnt_q;
  logic [VA_W-1:0] vcnt_q;
  logic [VA_W-1:0] row_q;
  logic [VA_W-1:0] col_q;
  logic            matrix_loaded_q;
  logic            mac_en_q;
  logic            mac_clr_q;
  logic            eff_new;
  logic            in_xfer;
`ifdef MATVEC_CTRL_PERF_EN
  logic [31:0]     perf_jobs_q;
  logic [31:0]     perf_stall_q;
`endif

  // Handshake, write strobes and address decode from the registered state
  always_comb begin
    input_ready  = (state_q == StIdle) || (state_q == StLoadM) || (state_q == StLoadV);
    in_xfer      = input_valid && input_ready;
    // new_matrix only matters on a job's first word; a job with no matrix loaded must load one
    eff_new      = new_matrix || !matrix_loaded_q;
    wr_en_m      = in_xfer && (((state_q == StIdle) && eff_new) || (state_q == StLoadM));
    wr_en_v      = in_xfer && (((state_q == StIdle) && !eff_new) || (state_q == StLoadV));
    wr_addr_m    = mcnt_q;
    wr_addr_v    = vcnt_q;
    // row/col stop at the last column, so read addresses hold outside compute
    rd_addr_m    = {row_q, col_q};
    rd_addr_v    = col_q;
    output_valid = (state_q == StOut);
    mac_en       = mac_en_q;
    mac_clr      = mac_clr_q;
`ifdef MATVEC_CTRL_PERF_EN
    perf_jobs    = perf_jobs_q;
    perf_stall   = perf_stall_q;
`endif
  end

  // Main FSM: load counters, row/column walk, MAC strobes one cycle behind the read
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      mcnt_q          <= '0;
      vcnt_q          <= '0;
      row_q           <= '0;
      col_q           <= '0;
      matrix_loaded_q <= 1'b0;
      mac_en_q        <= 1'b0;
      mac_clr_q       <= 1'b0;
`ifdef MATVEC_CTRL_PERF_EN
      perf_jobs_q     <= '0;
      perf_stall_q    <= '0;
`endif
    end else begin
      // Memory read latency is one cycle, so the product is ready the cycle after the read
      mac_en_q  <= (state_q == StCompute);
      mac_clr_q <= (state_q == StCompute) && (col_q == '0);
      case (state_q)
        StIdle: begin
          if (in_xfer) begin
            if (eff_new) begin
              mcnt_q  <= MA_W'(1);
              state_q <= StLoadM;
            end else begin
              vcnt_q  <= VA_W'(1);
              state_q <= StLoadV;
            end
          end
        end
        StLoadM: begin
          if (in_xfer) begin
            if (mcnt_q == MLast) begin
              matrix_loaded_q <= 1'b1;
              mcnt_q          <= '0;
              state_q         <= StLoadV;
            end else begin
              mcnt_q <= mcnt_q + 1'b1;
            end
          end
        end
        StLoadV: begin
          if (in_xfer) begin
            if (vcnt_q == VLast) begin
              vcnt_q  <= '0;
              row_q   <= '0;
              col_q   <= '0;
              state_q <= StCompute;
            end else begin
              vcnt_q <= vcnt_q + 1'b1;
            end
          end
        end
        StCompute: begin
          if (col_q == VLast) begin
            state_q <= StDrain;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        StDrain: begin
          state_q <= StOut;
        end
        StOut: begin
          if (output_ready) begin
            if (row_q == VLast) begin
              state_q <= StIdle;
`ifdef MATVEC_CTRL_PERF_EN
              perf_jobs_q <= perf_jobs_q + 32'd1;
`endif
            end else begin
              row_q   <= row_q + 1'b1;
              col_q   <= '0;
              state_q <= StCompute;
            end
          end else begin
`ifdef MATVEC_CTRL_PERF_EN
            perf_stall_q <= perf_stall_q + 32'd1;
`endif
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/matvec_ctrl.md
Name: matvec_ctrl

Overview:
Control unit that sequences the K×K matrix / K-vector multiply datapath.
- Accepts the 14-bit input stream handshake and generates matrix/vector memory write strobes and addresses.
- Schedules row-by-row MAC reads and drives the 28-bit result output handshake.
- Carries no data. The datapath (memories, MAC, accumulator register) instantiates this block and follows its strobes.

Parameters:
K, 8, matrix dimension (K ≥ 2, power of 2)
MA_W, $clog2(K*K), matrix address width (6 at default)
VA_W, $clog2(K), vector address width (3 at default)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
input_valid  in  1  upstream word valid
input_ready  out  1  controller can accept a word
new_matrix  in  1  job type flag; sampled only on a job's first word
output_valid  out  1  accumulator holds a finished row result
output_ready  in  1  downstream accepts result
wr_en_m  out  1  write matrix memory this cycle
wr_addr_m  out  MA_W  matrix write address, row-major
wr_en_v  out  1  write vector memory this cycle
wr_addr_v  out  VA_W  vector write address
rd_addr_m  out  MA_W  matrix read address (1-cycle read latency)
rd_addr_v  out  VA_W  vector read address
mac_en  out  1  accumulator captures a product this cycle
mac_clr  out  1  with mac_en: load the product instead of adding it

Behaviour:
- Transfer: input_valid && input_ready at a rising edge. Output transfer: output_valid && output_ready.
- Reset (synchronous, any state, including mid-load or mid-output):
  - state goes to S_IDLE; all counters and matrix_loaded flag go to 0.
  - After the reset edge: input_ready=1, all other outputs 0.
  - A partially loaded job is discarded.
- input_ready is 1 in S_IDLE, S_LOAD_M and S_LOAD_V, and 0 otherwise.
- wr_en_m / wr_en_v are combinational: transfer qualifier AND state. Write addresses equal the current load count.
- Effective job type: eff_new = new_matrix || !matrix_loaded.
  - new_matrix=0 on the first job after reset still loads a matrix.
  - new_matrix on non-first words is ignored (X-tolerant).
- S_IDLE, on a transfer:
  - eff_new=1: wr_en_m at address 0, mcnt←1, go to S_LOAD_M.
  - else: wr_en_v at address 0, vcnt←1, go to S_LOAD_V.
- S_LOAD_M: each transfer writes wr_addr_m=mcnt. After the word at K*K-1, set matrix_loaded=1, mcnt←0, go to S_LOAD_V.
- S_LOAD_V: each transfer writes wr_addr_v=vcnt. After the word at K-1, r←0, c←0, go to S_COMPUTE.
- S_COMPUTE, one cycle per column c = 0..K-1:
  - rd_addr_m = r*K+c, rd_addr_v = c.
  - Registered mac_en=1 in the following cycle; mac_clr=1 on that cycle when c was 0.
  - After c=K-1, go to S_DRAIN. No bubbles.
- S_DRAIN: one cycle. The last mac_en of the row fires here. Go to S_OUT.
- S_OUT: output_valid=1, held stable until the transfer.
  - On transfer: if r=K-1, go to S_IDLE; else r++, c←0, go to S_COMPUTE.
  - output_ready=0 stalls indefinitely.
- Latency:
  - First S_COMPUTE cycle to output_valid = K+1 cycles (9 at default).
  - Row throughput with output_ready=1 = K+2 cycles.
  - Job = loads + K*(K+2) cycles minimum.
- mac_en and mac_clr are never asserted outside the cycle after a S_COMPUTE cycle.
- Simultaneous input_valid during S_COMPUTE/S_DRAIN/S_OUT: ignored, because input_ready=0.
- Outputs driven when not meaningful: rd_addr_* hold their last value; wr_addr_* = count.

Optional Feature:
Macro MATVEC_CTRL_PERF_EN.
- Defined: adds 32-bit outputs perf_jobs (completed jobs, incremented on the final S_OUT transfer) and perf_stall (cycles in S_OUT with output_ready=0).
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then 64 matrix words (new_matrix=1 on first) and 8 vector words, all valid, output_ready=1 → wr_addr_m 0..63 and wr_addr_v 0..7 in order; 8 output_valid pulses, each 10 cycles apart; input_ready=0 from after word 72 until the 8th output transfer.
- Second job with new_matrix=0 → no wr_en_m; 8 vector writes then 8 outputs; rd_addr_m sequence 0..63.
- First job after reset with new_matrix=0 → treated as matrix load: wr_en_m for the first 64 words.
- output_ready held 0 for 20 cycles in S_OUT row 3 → output_valid stays 1, no mac_en, rd_addr frozen; perf_stall=20 when MATVEC_CTRL_PERF_EN is defined.
- Random input_valid/output_ready (50%) over 100 jobs → write addresses contiguous; exactly 800 output transfers; mac_clr count = 800, mac_en count = 6400; perf_jobs=100.
- Reset asserted mid S_LOAD_M (after word 30) → next cycle input_ready=1, all strobes 0; a new full job completes correctly.
